// File: rtl/serial_tx_16.sv
// Serial transmitter for one 16-bit word sent as two back-to-back 8N1 frames,
// low byte first, with registered busy/done handshake and a debug state port.
module serial_tx_16 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] data,
    output logic        serial_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  db_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_BIT = 4'd1,
        DATA_BITS = 4'd2,
        STOP_BIT  = 4'd3,
        DONE      = 4'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_q, byte_d;
    logic [15:0]   hold_q, hold_d;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= 1'b0;
            hold_q   <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            hold_q   <= hold_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = START_BIT;
                    hold_d  = data;
                    byte_d  = 1'b0;
                end
            end
            START_BIT: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    state_d = DATA_BITS;
                    bit_d   = 3'd0;
                end
            end
            DATA_BITS: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP_BIT: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    // Second frame follows the first stop bit with no idle gap.
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = START_BIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            START_BIT: begin
                serial_d = 1'b0;
                busy_d   = 1'b1;
            end
            DATA_BITS: begin
                serial_d = hold_d[{byte_d, bit_d}];
                busy_d   = 1'b1;
            end
            STOP_BIT: busy_d = 1'b1;
            DONE:     done_d = 1'b1;
            default: ;
        endcase
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign db_state   = state_q;

endmodule

// File: doc/serial_tx_16.md
Name: serial_tx_16

Overview:
- Transmit side for 16-bit data held in the design's parallel registers.
- On a start request, captures a 16-bit word and sends it on a single serial line as two UART-style 8N1 frames: low byte first, then high byte.
- Sits between a register bank output and a serial link (debug/UART pin).
- Provides busy/done handshaking to the controlling FSM.

Parameters:
- CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud). Legal range ≥ 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request to transmit; level sampled each clock edge.
- data  in  16  word to transmit; sampled only on the accepting edge.
- serial_out  out  1  serial line, idle high.
- busy  out  1  high while a transmission is in progress.
- done  out  1  one-cycle pulse after the last stop bit completes.
- db_state  out  4  current FSM state encoding, for debug.

Behaviour:
- Reset
  - One clock only, on the rising edge with reset_n=0.
  - Result: state=IDLE, serial_out=1, busy=0, done=0.
  - Internal holding register, bit counter, byte index and period counter are all cleared.
  - Applies in any state, including mid-frame; the line returns high on that same edge.
  - No partial frame resumes.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
- Accept
  - In IDLE or DONE, an edge with start=1 copies data into the 16-bit holding register.
  - It clears the byte index to 0 and enters START_BIT.
  - busy=1 from the next cycle.
- Ignored inputs
  - start while busy=1 is ignored, with no queuing.
  - data changes after acceptance have no effect.
- START_BIT: serial_out=0 for exactly CLKS_PER_BIT cycles, then DATA_BITS with bit counter=0.
- DATA_BITS
  - serial_out = holding[8*byte_index + bit_counter], LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit 7, enter STOP_BIT.
- STOP_BIT
  - serial_out=1 for CLKS_PER_BIT cycles.
  - If byte_index=0: set byte_index=1 and go to START_BIT, with no idle gap between frames.
  - Otherwise go to DONE.
- DONE
  - Lasts one cycle: done=1, busy=0, serial_out=1.
  - Then goes to IDLE, unless start=1 on that edge, which accepts a new word (back-to-back allowed).
- Timing
  - Period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit transition.
  - Width is ceil(log2(CLKS_PER_BIT)) bits.
- Latency
  - Accept at edge t.
  - Start bit of the low byte occupies cycles t+1 .. t+CLKS_PER_BIT.
  - The complete transfer is 20*CLKS_PER_BIT cycles.
  - done=1 in cycle t+1+20*CLKS_PER_BIT.
- Output behaviour
  - serial_out, busy and done are registered outputs: no combinational path from start or data.
  - busy=1 in START_BIT, DATA_BITS and STOP_BIT only.
- db_state encoding: IDLE=0, START_BIT=1, DATA_BITS=2, STOP_BIT=3, DONE=4.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> serial_out=1, busy=0, done=0, db_state=0; no transmission begins.
- Basic frame: CLKS_PER_BIT=4, data=16'hA53C, start pulse 1 cycle.
  - Sampling mid-bit every 4 cycles must give 0, 0,0,1,1,1,1,0,0, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses exactly at cycle 81 after accept; busy=1 for 80 cycles.
- Ignore while busy: during a 16'hA53C transfer, assert start with data=16'hFFFF at cycle 30 -> waveform unchanged from the basic case; a single done pulse.
- Back-to-back: hold start=1 continuously with data=16'h0001, then 16'h8000.
  - Second start bit begins the cycle after done.
  - Second transfer's low byte is all zeros; its high byte has bit 7 = 1.
- Reset mid-frame: assert reset_n=0 at cycle 37 of a transfer -> next edge serial_out=1, busy=0, done never pulses.
  - A new start after release transmits the full new word correctly.
- Edge values with CLKS_PER_BIT=2: data=16'h0000 and 16'hFFFF -> each bit exactly 2 cycles wide; total busy=40 cycles.
